// File: rtl/s2b_pkg.sv
// ---------------------------------------------------------------------------
// s2b_pkg
// Shared types and constants for the unipolar stochastic-to-binary converter.
//   s2b_state_t     : converter FSM state (IDLE / ACC / HOLD)
//   S2B_DATAWD_DEF  : default binary result width, shared with the dMUL benches
// ---------------------------------------------------------------------------
package s2b_pkg;

    localparam int S2B_DATAWD_DEF = 8;

    typedef enum logic [1:0] {
        S2B_IDLE = 2'd0,
        S2B_ACC  = 2'd1,
        S2B_HOLD = 2'd2
    } s2b_state_t;

endpackage

// File: rtl/s2b_win_cnt.sv
// ---------------------------------------------------------------------------
// s2b_win_cnt
// Window counter for the stochastic-to-binary converter. Counts sampled
// cycles inside a window of 2^kq cycles and flags the last one.
// Ports:
//   clk     in  1       clock, rising edge
//   rst_n   in  1       synchronous active-low reset
//   i_load  in  1       clear the count (new window accepted)
//   i_en    in  1       count this cycle (window is accumulating)
//   i_kq    in  LSELWD  window exponent, already clamped to 1..DATAWD
//   o_tc    out 1       terminal count: enabled and count == 2^kq-1
// ---------------------------------------------------------------------------
module s2b_win_cnt #(
    parameter int DATAWD = 8,
    parameter int LSELWD = $clog2(DATAWD + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_en,
    input  logic [LSELWD-1:0] i_kq,
    output logic              o_tc
);

    logic [DATAWD-1:0] r_cnt;
    logic [DATAWD-1:0] w_mask;

    // In DATAWD bits, 1 << DATAWD wraps to zero and the decrement yields
    // all ones, so the mask is correct for every kq in 1..DATAWD.
    assign w_mask = ({{(DATAWD-1){1'b0}}, 1'b1} << i_kq) - {{(DATAWD-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + {{(DATAWD-1){1'b0}}, 1'b1};
        end
    end

    // Only the low kq bits matter, so the count never has to wrap in-window.
    assign o_tc = i_en && ((r_cnt & w_mask) == w_mask);

endmodule

// File: rtl/s2b_win_uni.sv
// ---------------------------------------------------------------------------
// s2b_win_uni
// Unipolar stochastic-to-binary converter. Counts ones on iBit over a window
// of 2^kq cycles (kq chosen at start time), normalises the count to DATAWD
// bits with saturation and presents it on a valid/ready output.
// Ports:
//   clk        in  1       clock, rising edge
//   rst_n      in  1       synchronous active-low reset
//   iStart     in  1       request a new window (pulse or level)
//   iLenSel    in  LSELWD  window exponent k, sampled when a start is accepted
//   iBit       in  1       stochastic bit stream
//   oBusy      out 1       window is being accumulated
//   oValid     out 1       result available
//   iReady     in  1       consumer takes the result when oValid & iReady
//   oData      out DATAWD  normalised result, registered
//   oDbgState  out 2       current FSM state, for observation only
//
// Handshake: the result transfers on any rising edge where oValid and iReady
// are both high; oData is stable from oValid rising until that edge. A start
// in the same transfer cycle begins the next window immediately.
// ---------------------------------------------------------------------------
import s2b_pkg::*;

module s2b_win_uni #(
    parameter int DATAWD = S2B_DATAWD_DEF,
    parameter int LSELWD = $clog2(DATAWD + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iStart,
    input  logic [LSELWD-1:0] iLenSel,
    input  logic              iBit,
    output logic              oBusy,
    output logic              oValid,
    input  logic              iReady,
    output logic [DATAWD-1:0] oData,
    output s2b_state_t        oDbgState
);

    localparam logic [LSELWD-1:0] KQ_MAX = LSELWD'(DATAWD);

    s2b_state_t        r_state;
    s2b_state_t        w_next_state;
    logic [LSELWD-1:0] r_kq;
    logic [DATAWD:0]   r_acc;
    logic [DATAWD-1:0] r_data;

    logic              w_start_acc;
    logic              w_in_acc;
    logic              w_tc;
    logic [LSELWD-1:0] w_kq_sel;
    logic [LSELWD-1:0] w_shamt;
    logic [DATAWD:0]   w_sum;
    logic [DATAWD:0]   w_shift;
    logic [DATAWD-1:0] w_sat;

    // A start is accepted from IDLE, or from HOLD only together with a transfer.
    assign w_start_acc = iStart &&
                         ((r_state == S2B_IDLE) || ((r_state == S2B_HOLD) && iReady));
    assign w_in_acc    = (r_state == S2B_ACC);

    // Out-of-range exponents (0 or above DATAWD) select the longest window.
    assign w_kq_sel = ((iLenSel == '0) || (iLenSel > KQ_MAX)) ? KQ_MAX : iLenSel;

    // The final sample is folded in combinationally so the result can be
    // registered on the terminal cycle itself.
    assign w_sum   = r_acc + {{DATAWD{1'b0}}, iBit};
    assign w_shamt = KQ_MAX - r_kq;
    // w_sum <= 2^kq, so the shifted value is at most 2^DATAWD and fits here.
    assign w_shift = w_sum << w_shamt;
    assign w_sat   = w_shift[DATAWD] ? {DATAWD{1'b1}} : w_shift[DATAWD-1:0];

    s2b_win_cnt #(
        .DATAWD (DATAWD),
        .LSELWD (LSELWD)
    ) u_win_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_start_acc),
        .i_en   (w_in_acc),
        .i_kq   (r_kq),
        .o_tc   (w_tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S2B_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S2B_IDLE: begin
                if (iStart) begin
                    w_next_state = S2B_ACC;
                end
            end
            S2B_ACC: begin
                if (w_tc) begin
                    w_next_state = S2B_HOLD;
                end
            end
            S2B_HOLD: begin
                if (iReady) begin
                    w_next_state = iStart ? S2B_ACC : S2B_IDLE;
                end
            end
            default: begin
                w_next_state = S2B_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        oBusy     = (r_state == S2B_ACC);
        oValid    = (r_state == S2B_HOLD);
        oData     = r_data;
        oDbgState = r_state;
    end

    // Datapath: window exponent, accumulator and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_kq   <= '0;
            r_acc  <= '0;
            r_data <= '0;
        end else if (w_start_acc) begin
            r_kq  <= w_kq_sel;
            r_acc <= '0;
        end else if (w_in_acc) begin
            r_acc <= w_sum;
            if (w_tc) begin
                r_data <= w_sat;
            end
        end
    end

endmodule

// File: tb/tb_s2b_win_uni.sv
// ---------------------------------------------------------------------------
// tb_s2b_win_uni
// Self-checking bench for s2b_win_uni. A window-level model predicts busy,
// valid and data every cycle; directed windows carry hand-computed results.
// ---------------------------------------------------------------------------
module tb_s2b_win_uni;
    import s2b_pkg::*;

    localparam int DW = 8;
    localparam int LW = $clog2(DW + 1);

    // ---------------- clock / reset / signals ----------------
    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          iStart  = 1'b0;
    logic [LW-1:0] iLenSel = '0;
    logic          iBit    = 1'b0;
    logic          iReady  = 1'b0;
    logic          oBusy;
    logic          oValid;
    logic [DW-1:0] oData;
    s2b_state_t    oDbgState;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    s2b_win_uni #(.DATAWD(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iStart    (iStart),
        .iLenSel   (iLenSel),
        .iBit      (iBit),
        .oBusy     (oBusy),
        .oValid    (oValid),
        .iReady    (iReady),
        .oData     (oData),
        .oDbgState (oDbgState)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- window-level model ----------------
    function automatic int eff_k(input int sel);
        return (sel == 0 || sel > DW) ? DW : sel;
    endfunction

    function automatic int result_of(input int ones, input int k);
        int v;
        v = ones * (1 << (DW - k));
        return (v > (1 << DW) - 1) ? (1 << DW) - 1 : v;
    endfunction

    int            m_remaining = 0;
    int            m_ones      = 0;
    int            m_k         = DW;
    bit            m_pending   = 1'b0;
    logic [DW-1:0] m_data      = '0;
    logic [DW-1:0] exp_q[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_remaining <= 0;
            m_ones      <= 0;
            m_pending   <= 1'b0;
            m_data      <= '0;
            exp_q.delete();
        end else if (m_remaining > 0) begin
            m_ones      <= m_ones + int'(iBit);
            m_remaining <= m_remaining - 1;
            if (m_remaining == 1) begin
                m_data    <= DW'(result_of(m_ones + int'(iBit), m_k));
                m_pending <= 1'b1;
                exp_q.push_back(DW'(result_of(m_ones + int'(iBit), m_k)));
            end
        end else if (m_pending) begin
            if (iReady) begin
                m_pending <= 1'b0;
                if (iStart) begin
                    m_k         <= eff_k(int'(iLenSel));
                    m_remaining <= 1 << eff_k(int'(iLenSel));
                    m_ones      <= 0;
                end
            end
        end else if (iStart) begin
            m_k         <= eff_k(int'(iLenSel));
            m_remaining <= 1 << eff_k(int'(iLenSel));
            m_ones      <= 0;
        end
    end

    // ---------------- per-cycle compare + scoreboard ----------------
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            check("cyc_busy",  oBusy,  (m_remaining > 0));
            check("cyc_valid", oValid, m_pending);
            check("cyc_data",  oData,  m_data);
            if (oValid && iReady) begin
                if (exp_q.size() > 0) begin
                    check("sb_data", oData, exp_q.pop_front());
                end else begin
                    check("sb_size", exp_q.size(), 1);
                end
            end
        end
    end

    // ---------------- stimulus patterns ----------------
    function automatic logic dmul_bit(input int i);
        logic [7:0] c;
        logic [7:0] r;
        c = i[7:0];
        for (int b = 0; b < 8; b++) r[b] = c[7-b];
        return (c < 8'd128) && (r < 8'd64);
    endfunction

    function automatic logic pat(input int kind, input int i);
        case (kind)
            0:       return 1'b1;
            1:       return (i % 4) == 3;
            2:       return (i == 0) || (i == 3) || (i == 7) || (i == 8) || (i == 15);
            3:       return dmul_bit(i);
            default: return (i % 3) == 0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Starts from IDLE, feeds a full window, and leaves the bench at the
    // negedge of the first HOLD cycle with the literal result checked.
    task automatic run_window(input int sel, input int kind, input int exp_data, input string tag);
        int n;
        n = 1 << eff_k(sel);
        @(negedge clk);
        iStart  = 1'b1;
        iLenSel = LW'(sel);
        iBit    = 1'b1;                 // start-cycle bit must not be counted
        @(negedge clk);
        iStart  = 1'b0;
        iLenSel = LW'(3);               // later changes must have no effect
        for (int i = 0; i < n; i++) begin
            if (i == 0)     check({tag, "_busy_first"}, oBusy, 1);
            if (i == n - 1) check({tag, "_valid_early"}, oValid, 0);
            iBit = pat(kind, i);
            @(negedge clk);
        end
        iBit = 1'b0;
        check({tag, "_valid_lat"}, oValid, 1);
        check({tag, "_data"}, oData, exp_data);
    endtask

    task automatic accept(input bit restart, input int sel);
        iReady  = 1'b1;
        iStart  = restart;
        iLenSel = LW'(sel);
        @(negedge clk);
        iReady  = 1'b0;
        iStart  = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // 1. reset held with start and bit asserted
        rst_n   = 1'b0;
        iStart  = 1'b1;
        iBit    = 1'b1;
        iLenSel = LW'(4);
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_busy",  oBusy,  0);
            check("rst_valid", oValid, 0);
            check("rst_data",  oData,  0);
        end
        rst_n  = 1'b1;
        iStart = 1'b0;
        iBit   = 1'b0;
        repeat (2) @(negedge clk);

        // 2. kq=8, all ones -> saturated
        run_window(8, 0, 255, "k8_ones");
        accept(1'b0, 0);
        check("k8_ones_after_acc", oValid, 0);

        // 3. kq=8, every 4th bit; out-of-range selects behave as kq=8
        run_window(8, 1, 64, "k8_q");
        accept(1'b0, 0);
        run_window(0, 1, 64, "k0_q");
        accept(1'b0, 0);
        run_window(9, 1, 64, "k9_q");
        accept(1'b0, 0);

        // 4. kq=4, five ones in sixteen
        run_window(4, 2, 80, "k4_five");
        accept(1'b0, 0);

        // 5. backpressure, then back-to-back restart
        run_window(2, 4, 128, "k2_bp");
        for (int c = 0; c < 10; c++) begin
            iReady = 1'b0;
            iStart = c[0];
            iBit   = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp_valid", oValid, 1);
            check("bp_data",  oData,  128);
            check("bp_busy",  oBusy,  0);
        end
        iBit = 1'b0;
        accept(1'b1, 1);
        check("b2b_busy",  oBusy,  1);
        check("b2b_valid", oValid, 0);
        iBit = 1'b1;
        repeat (2) @(negedge clk);
        iBit = 1'b0;
        check("k1_valid", oValid, 1);
        check("k1_sat",   oData,  255);
        accept(1'b0, 0);

        // 6. dMUL-style stream: 128/256 * 64/256 -> 32
        run_window(8, 3, 32, "dmul");
        accept(1'b0, 0);

        // reset in the middle of a window
        @(negedge clk);
        iStart  = 1'b1;
        iLenSel = LW'(8);
        @(negedge clk);
        iStart = 1'b0;
        iBit   = 1'b1;
        repeat (100) @(negedge clk);
        check("mid_busy", oBusy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_busy",  oBusy,  0);
        check("mid_rst_valid", oValid, 0);
        check("mid_rst_data",  oData,  0);
        repeat (300) @(negedge clk);
        check("mid_no_valid", oValid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
